// File: rtl/rx_word_fifo.sv
// rx_word_fifo: receive-side word buffer behind the serial-in/parallel-out
// shift register. Words are captured on the single-cycle in_valid strobe
// and stored in a DEPTH-entry circular buffer. The consumer reads them
// through a show-ahead valid/ready interface. A sticky flag records lost
// words.
//
// Optional build macro RX_FIFO_OVERWRITE_EN: when the buffer is full and
// no pop occurs, the oldest word is discarded to make room for the new
// word. By default the new word is dropped instead. The overflow flag is
// set in both builds.
module rx_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [WIDTH-1:0]         in_word,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             overflow_r;

    logic             full_s;
    logic             out_valid_s;
    logic             pop_s;
    logic             push_s;
    logic             ovf_evt_s;
    logic             wr_en_s;
    logic             rd_adv_s;
    logic [AW:0]      level_nxt_s;

    // Derive push/pop/overflow decisions and the next level from registered state and inputs.
    always_comb begin
        full_s      = 1'b0;
        out_valid_s = 1'b0;
        pop_s       = 1'b0;
        push_s      = 1'b0;
        ovf_evt_s   = 1'b0;
        wr_en_s     = 1'b0;
        rd_adv_s    = 1'b0;
        level_nxt_s = level_r;

        full_s      = (level_r == FULL_LEVEL);
        out_valid_s = (level_r != {(AW+1){1'b0}});
        // A pop request on an empty buffer is ignored.
        pop_s       = out_valid_s && out_ready;
        // A full buffer still accepts a word when a pop frees a slot in the same cycle.
        push_s      = in_valid && (!full_s || pop_s);
        ovf_evt_s   = in_valid && full_s && !pop_s;
`ifdef RX_FIFO_OVERWRITE_EN
        // Overwrite: drop the oldest entry and store the new word. Level is unchanged.
        wr_en_s     = push_s || ovf_evt_s;
        rd_adv_s    = pop_s || ovf_evt_s;
`else
        wr_en_s     = push_s;
        rd_adv_s    = pop_s;
`endif
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + (AW+1)'(1);
            2'b01:   level_nxt_s = level_r - (AW+1)'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Storage array write port. The array has no reset; validity is tracked by level.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= in_word;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and level. Reset discards all stored words immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r <= level_nxt_s;
        end
    end

    // Sticky overflow flag. A new loss event takes priority over a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_r <= 1'b0;
        end else if (ovf_evt_s) begin
            overflow_r <= 1'b1;
        end else if (clear_overflow) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Outputs depend only on registered state. out_word reads as zero while the buffer is empty.
    assign out_valid = out_valid_s;
    assign out_word  = out_valid_s ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    assign level     = level_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_rx_word_fifo.sv
// Self-checking bench for rx_word_fifo. A queue-based model tracks the
// expected contents and the overflow flag. A negedge process compares every
// output against the model. Directed phases add literal expectations.
module tb_rx_word_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rstn;
    logic [WIDTH-1:0] in_word;
    logic             in_valid;
    logic [WIDTH-1:0] out_word;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             clear_overflow;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [WIDTH-1:0] mq[$];        // model contents, head at index 0
    bit               m_ovf;
    logic [WIDTH-1:0] dut_drained[$];
    logic [WIDTH-1:0] exp_q[$];

    rx_word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_word        (in_word),
        .in_valid       (in_valid),
        .out_word       (out_word),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("cmp_level", 64'(level), 64'(mq.size()));
            chk("cmp_word", 64'(out_word), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
            chk("cmp_ovf", 64'(overflow), 64'(m_ovf));
        end
    end

    // One clock cycle: drive inputs, record DUT pops, advance the model at the edge.
    task automatic step(input bit v, input logic [WIDTH-1:0] w, input bit r, input bit clr);
        bit full;
        bit pop;
        bit evt;
        in_valid       = v;
        in_word        = w;
        out_ready      = r;
        clear_overflow = clr;
        if (out_valid && out_ready) dut_drained.push_back(out_word);
        @(posedge clk);
        full = (mq.size() == DEPTH);
        pop  = (mq.size() != 0) && r;
        evt  = 1'b0;
        if (pop) void'(mq.pop_front());
        if (v) begin
            if (!full || pop) begin
                mq.push_back(w);
            end else begin
                evt = 1'b1;
`ifdef RX_FIFO_OVERWRITE_EN
                void'(mq.pop_front());
                mq.push_back(w);
`endif
            end
        end
        if (evt) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
    endtask

    task automatic fill(input int n);
        for (int i = 1; i <= n; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic chk_seq(input string name);
        chk({name, "_len"}, 64'(dut_drained.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < dut_drained.size(); i++)
            chk(name, 64'(dut_drained[i]), 64'(exp_q[i]));
        dut_drained.delete();
        exp_q.delete();
    endtask

    initial begin
        bit               rv;
        bit               rr;
        bit               rc;
        logic [WIDTH-1:0] rw;
        rstn = 1'b0; in_word = '0; in_valid = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        chk_en = 1'b1;

        // Reset then idle.
        step(1'b0, '0, 1'b0, 1'b0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_word", 64'(out_word), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Single word.
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_word", 64'(out_word), 64'hDEADBEEF);
        chk("single_level", 64'(level), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("single_pop_valid", 64'(out_valid), 64'd0);
        chk("single_pop_level", 64'(level), 64'd0);
        dut_drained.delete();

        // Fill and wrap.
        fill(8);
        chk("fill_level", 64'(level), 64'd8);
        drain(3);
        for (int i = 9; i <= 11; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
        chk("wrap_level", 64'(level), 64'd8);
        drain(8);
        for (int i = 1; i <= 11; i++) exp_q.push_back(WIDTH'(i));
        chk_seq("wrap_order");

        // Overflow on a full buffer.
        fill(8);
        step(1'b1, WIDTH'(99), 1'b0, 1'b0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_level", 64'(level), 64'd8);
`ifdef RX_FIFO_OVERWRITE_EN
        chk("ovw_head", 64'(out_word), 64'd2);
        drain(8);
        for (int i = 2; i <= 8; i++) exp_q.push_back(WIDTH'(i));
        exp_q.push_back(WIDTH'(99));
`else
        drain(8);
        for (int i = 1; i <= 8; i++) exp_q.push_back(WIDTH'(i));
`endif
        chk_seq("ovf_order");
        chk("ovf_sticky", 64'(overflow), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clear", 64'(overflow), 64'd0);

        // A set that coincides with a clear leaves the flag set.
        fill(8);
        step(1'b1, WIDTH'(77), 1'b0, 1'b1);
        chk("ovf_set_wins", 64'(overflow), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clear2", 64'(overflow), 64'd0);
        drain(8);
        dut_drained.delete();

        // Push and pop together on a full buffer.
        fill(8);
        step(1'b1, WIDTH'(50), 1'b1, 1'b0);
        chk("fullpp_level", 64'(level), 64'd8);
        chk("fullpp_ovf", 64'(overflow), 64'd0);
        chk("fullpp_head", 64'(out_word), 64'd2);
        drain(8);
        for (int i = 1; i <= 8; i++) exp_q.push_back(WIDTH'(i));
        exp_q.push_back(WIDTH'(50));
        chk_seq("fullpp_order");

        // Push and pop together on an empty buffer: the pop is ignored.
        step(1'b1, WIDTH'(5), 1'b1, 1'b0);
        chk("emptypp_level", 64'(level), 64'd1);
        chk("emptypp_word", 64'(out_word), 64'd5);
        chk("emptypp_drained", 64'(dut_drained.size()), 64'd0);
        drain(1);
        dut_drained.delete();

        // Pseudo-random traffic, checked by the per-cycle model comparison.
        for (int i = 0; i < 300; i++) begin
            rv = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 2) == 0);
            rc = ($urandom_range(0, 15) == 0);
            rw = WIDTH'($urandom);
            step(rv, rw, rr, rc);
        end
        dut_drained.delete();

        // Asynchronous reset in mid-operation empties the buffer without a clock edge.
        fill(3);
        #2;
        chk_en = 1'b0;
        rstn = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_word", 64'(out_word), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        chk_en = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        chk("arst_idle_level", 64'(level), 64'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
